// File: rtl/btle_phy_arbiter.sv
// btle_phy_arbiter
// -----------------------------------------------------------------------------
// Shares one btle_phy between NUM_MASTER link-layer clients. Clients are served
// one at a time in round-robin order. For each grant the arbiter latches that
// client's radio configuration, runs one TX on the PHY, and then either finishes
// straight away or opens an IFS-timed RX window. When the transaction ends it
// sends a one-cycle done pulse and a status word back to the owning client.
//
// Ports
//   clk, rst                  : system clock, synchronous active-high reset
//   req[k]                    : client k wants the PHY (level, held until done[k])
//   req_rx_after_tx[k]        : client k wants an RX window after its TX
//   req_access_address        : 32 bits per client, client k at slice k
//   req_channel_number        : CHANNEL_NUMBER_BIT_WIDTH bits per client
//   req_crc_state_init_bit    : CRC_STATE_BIT_WIDTH bits per client
//   gnt                       : one-hot owner, high from LOAD through DONE
//   done                      : one-cycle pulse to the owner at transaction end
//   status_crc_ok/timeout/payload_length : transaction status, valid with done
//   tx_* outputs              : latched TX configuration and load/start pulses
//   tx_iq_valid_last          : PHY marks the last TX sample
//   rx_* outputs              : latched RX configuration and RX window enable
//   rx_hit_flag, rx_decode_end, rx_crc_ok, rx_payload_length : PHY RX results
// -----------------------------------------------------------------------------
module btle_phy_arbiter #(
   parameter int NUM_MASTER               = 2,
   parameter int CRC_STATE_BIT_WIDTH      = 24,
   parameter int CHANNEL_NUMBER_BIT_WIDTH = 6,
   parameter int IFS_CYCLES               = 2400,
   parameter int RX_WIN_CYCLES            = 640,
   parameter int TIMER_BIT_WIDTH          = 16
) (
   input  logic                                           clk,
   input  logic                                           rst,
   input  logic [NUM_MASTER-1:0]                          req,
   input  logic [NUM_MASTER-1:0]                          req_rx_after_tx,
   input  logic [32*NUM_MASTER-1:0]                       req_access_address,
   input  logic [CHANNEL_NUMBER_BIT_WIDTH*NUM_MASTER-1:0] req_channel_number,
   input  logic [CRC_STATE_BIT_WIDTH*NUM_MASTER-1:0]      req_crc_state_init_bit,
   output logic [NUM_MASTER-1:0]                          gnt,
   output logic [NUM_MASTER-1:0]                          done,
   output logic                                           status_crc_ok,
   output logic                                           status_timeout,
   output logic [6:0]                                     status_payload_length,
   output logic [31:0]                                    tx_access_address,
   output logic [CRC_STATE_BIT_WIDTH-1:0]                 tx_crc_state_init_bit,
   output logic [CHANNEL_NUMBER_BIT_WIDTH-1:0]            tx_channel_number,
   output logic                                           tx_crc_state_init_bit_load,
   output logic                                           tx_channel_number_load,
   output logic                                           tx_start,
   input  logic                                           tx_iq_valid_last,
   output logic [31:0]                                    rx_unique_bit_sequence,
   output logic [CHANNEL_NUMBER_BIT_WIDTH-1:0]            rx_channel_number,
   output logic [CRC_STATE_BIT_WIDTH-1:0]                 rx_crc_state_init_bit,
   output logic                                           rx_enable,
   input  logic                                           rx_hit_flag,
   input  logic                                           rx_decode_end,
   input  logic                                           rx_crc_ok,
   input  logic [6:0]                                     rx_payload_length
);

   localparam int IDX_W = (NUM_MASTER > 1) ? $clog2(NUM_MASTER) : 1;
   localparam logic [NUM_MASTER-1:0] ONE = NUM_MASTER'(1);
   localparam logic [TIMER_BIT_WIDTH-1:0] IFS_LOAD = TIMER_BIT_WIDTH'(IFS_CYCLES - 1);
   localparam logic [TIMER_BIT_WIDTH-1:0] RXW_LOAD = TIMER_BIT_WIDTH'(RX_WIN_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_TX_WAIT,
      S_IFS,
      S_RX_WAIT,
      S_DONE
   } state_t;

   state_t                              state;
   logic [IDX_W-1:0]                    rr_ptr;
   logic [IDX_W-1:0]                    owner;
   logic                                rx_after;
   logic                                hit_sticky;
   logic [TIMER_BIT_WIDTH-1:0]          timer;
   logic [31:0]                         cfg_access_address;
   logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] cfg_channel_number;
   logic [CRC_STATE_BIT_WIDTH-1:0]      cfg_crc_state_init_bit;

   logic                                pick_valid;
   logic [IDX_W-1:0]                    pick_idx;
   logic [IDX_W-1:0]                    cand_idx;
   int                                  cand;

   // The latched configuration drives both the TX and RX sides of the PHY.
   // The RX correlator looks for the same access address the TX just sent.
   assign tx_access_address      = cfg_access_address;
   assign tx_channel_number      = cfg_channel_number;
   assign tx_crc_state_init_bit  = cfg_crc_state_init_bit;
   assign rx_unique_bit_sequence = cfg_access_address;
   assign rx_channel_number      = cfg_channel_number;
   assign rx_crc_state_init_bit  = cfg_crc_state_init_bit;

   // Round-robin pick: scan from rr_ptr upward with wrap-around. The loop
   // runs from the farthest offset down to the nearest, so the requester
   // closest to rr_ptr is the last one written and therefore wins.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      cand       = 0;
      cand_idx   = '0;
      for (int i = NUM_MASTER - 1; i >= 0; i--) begin
         cand = int'(rr_ptr) + i;
         if (cand >= NUM_MASTER) begin
            cand = cand - NUM_MASTER;
         end
         cand_idx = IDX_W'(cand);
         if (req[cand_idx]) begin
            pick_valid = 1'b1;
            pick_idx   = cand_idx;
         end
      end
   end

   // Transaction sequencer. Every output is a register updated here, so each
   // pulse is set on the transition into the state that owns it and cleared on
   // the way out. A reset mid-transaction simply drops everything. The PHY
   // gets no abort notification and has to recover on its own.
   always_ff @(posedge clk) begin
      if (rst) begin
         state                      <= S_IDLE;
         rr_ptr                     <= '0;
         owner                      <= '0;
         rx_after                   <= 1'b0;
         hit_sticky                 <= 1'b0;
         timer                      <= '0;
         cfg_access_address         <= '0;
         cfg_channel_number         <= '0;
         cfg_crc_state_init_bit     <= '0;
         gnt                        <= '0;
         done                       <= '0;
         status_crc_ok              <= 1'b0;
         status_timeout             <= 1'b0;
         status_payload_length      <= '0;
         tx_crc_state_init_bit_load <= 1'b0;
         tx_channel_number_load     <= 1'b0;
         tx_start                   <= 1'b0;
         rx_enable                  <= 1'b0;
      end else begin
         tx_crc_state_init_bit_load <= 1'b0;
         tx_channel_number_load     <= 1'b0;
         tx_start                   <= 1'b0;

         case (state)
            S_IDLE: begin
               if (pick_valid) begin
                  owner <= pick_idx;
                  gnt   <= ONE << pick_idx;
                  state <= S_LOAD;
               end
            end

            S_LOAD: begin
               cfg_access_address     <= req_access_address[32*int'(owner) +: 32];
               cfg_channel_number     <= req_channel_number[CHANNEL_NUMBER_BIT_WIDTH*int'(owner) +: CHANNEL_NUMBER_BIT_WIDTH];
               cfg_crc_state_init_bit <= req_crc_state_init_bit[CRC_STATE_BIT_WIDTH*int'(owner) +: CRC_STATE_BIT_WIDTH];
               rx_after               <= req_rx_after_tx[owner];
               hit_sticky             <= 1'b0;
               tx_crc_state_init_bit_load <= 1'b1;
               tx_channel_number_load     <= 1'b1;
               tx_start                   <= 1'b1;
               state                      <= S_START;
            end

            S_START: begin
               state <= S_TX_WAIT;
            end

            S_TX_WAIT: begin
               if (tx_iq_valid_last) begin
                  if (rx_after) begin
                     timer <= IFS_LOAD;
                     state <= S_IFS;
                  end else begin
                     done                  <= ONE << owner;
                     status_crc_ok         <= 1'b0;
                     status_timeout        <= 1'b0;
                     status_payload_length <= '0;
                     state                 <= S_DONE;
                  end
               end
            end

            S_IFS: begin
               if (timer == '0) begin
                  timer     <= RXW_LOAD;
                  rx_enable <= 1'b1;
                  state     <= S_RX_WAIT;
               end else begin
                  timer <= timer - 1'b1;
               end
            end

            // A decode end always beats the timeout, even in the same cycle.
            // Once a hit has been seen the window can no longer time out,
            // because the packet is already being received and only the
            // decoder can close it.
            S_RX_WAIT: begin
               if (rx_decode_end) begin
                  done                  <= ONE << owner;
                  status_crc_ok         <= rx_crc_ok;
                  status_timeout        <= 1'b0;
                  status_payload_length <= rx_payload_length;
                  rx_enable             <= 1'b0;
                  state                 <= S_DONE;
               end else begin
                  if (rx_hit_flag) begin
                     hit_sticky <= 1'b1;
                  end
                  if (!(hit_sticky || rx_hit_flag)) begin
                     if (timer == '0) begin
                        done                  <= ONE << owner;
                        status_crc_ok         <= 1'b0;
                        status_timeout        <= 1'b1;
                        status_payload_length <= '0;
                        rx_enable             <= 1'b0;
                        state                 <= S_DONE;
                     end else begin
                        timer <= timer - 1'b1;
                     end
                  end
               end
            end

            S_DONE: begin
               done                  <= '0;
               gnt                   <= '0;
               status_crc_ok         <= 1'b0;
               status_timeout        <= 1'b0;
               status_payload_length <= '0;
               hit_sticky            <= 1'b0;
               if (int'(owner) == NUM_MASTER - 1) begin
                  rr_ptr <= '0;
               end else begin
                  rr_ptr <= owner + 1'b1;
               end
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_btle_phy_arbiter.sv
// tb_btle_phy_arbiter
// -----------------------------------------------------------------------------
// Directed bench for btle_phy_arbiter with two clients. A timestamp-based
// transaction model predicts every output on every cycle, and literal timing
// and status expectations pin down the key scenarios.
// -----------------------------------------------------------------------------
module tb_btle_phy_arbiter;

   localparam int NUM  = 2;
   localparam int CRCW = 24;
   localparam int CHW  = 6;
   localparam int IFS  = 2400;
   localparam int RXW  = 640;

   logic              clk;
   logic              rst;
   logic [NUM-1:0]    req;
   logic [NUM-1:0]    req_rx_after_tx;
   logic [32*NUM-1:0] req_access_address;
   logic [CHW*NUM-1:0]  req_channel_number;
   logic [CRCW*NUM-1:0] req_crc_state_init_bit;
   logic [NUM-1:0]    gnt;
   logic [NUM-1:0]    done;
   logic              status_crc_ok;
   logic              status_timeout;
   logic [6:0]        status_payload_length;
   logic [31:0]       tx_access_address;
   logic [CRCW-1:0]   tx_crc_state_init_bit;
   logic [CHW-1:0]    tx_channel_number;
   logic              tx_crc_state_init_bit_load;
   logic              tx_channel_number_load;
   logic              tx_start;
   logic              tx_iq_valid_last;
   logic [31:0]       rx_unique_bit_sequence;
   logic [CHW-1:0]    rx_channel_number;
   logic [CRCW-1:0]   rx_crc_state_init_bit;
   logic              rx_enable;
   logic              rx_hit_flag;
   logic              rx_decode_end;
   logic              rx_crc_ok;
   logic [6:0]        rx_payload_length;

   btle_phy_arbiter #(
      .NUM_MASTER(NUM),
      .CRC_STATE_BIT_WIDTH(CRCW),
      .CHANNEL_NUMBER_BIT_WIDTH(CHW),
      .IFS_CYCLES(IFS),
      .RX_WIN_CYCLES(RXW),
      .TIMER_BIT_WIDTH(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req(req),
      .req_rx_after_tx(req_rx_after_tx),
      .req_access_address(req_access_address),
      .req_channel_number(req_channel_number),
      .req_crc_state_init_bit(req_crc_state_init_bit),
      .gnt(gnt),
      .done(done),
      .status_crc_ok(status_crc_ok),
      .status_timeout(status_timeout),
      .status_payload_length(status_payload_length),
      .tx_access_address(tx_access_address),
      .tx_crc_state_init_bit(tx_crc_state_init_bit),
      .tx_channel_number(tx_channel_number),
      .tx_crc_state_init_bit_load(tx_crc_state_init_bit_load),
      .tx_channel_number_load(tx_channel_number_load),
      .tx_start(tx_start),
      .tx_iq_valid_last(tx_iq_valid_last),
      .rx_unique_bit_sequence(rx_unique_bit_sequence),
      .rx_channel_number(rx_channel_number),
      .rx_crc_state_init_bit(rx_crc_state_init_bit),
      .rx_enable(rx_enable),
      .rx_hit_flag(rx_hit_flag),
      .rx_decode_end(rx_decode_end),
      .rx_crc_ok(rx_crc_ok),
      .rx_payload_length(rx_payload_length)
   );

   // 100 MHz-style bench clock, the period is arbitrary.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit armed = 0;

   // Transaction model: one record per grant, with timestamps of the
   // interesting events. Outputs are derived from "which cycle are we in".
   int          m_owner     = -1;
   int          m_rr        = 0;
   int          m_idle_from = 0;
   int          m_g, m_txend, m_rxen, m_toat, m_done_at;
   bit          m_rxf, m_hit, m_crc, m_to;
   logic [6:0]  m_len;
   logic [31:0] m_aa;
   logic [CHW-1:0]  m_ch;
   logic [CRCW-1:0] m_crcinit;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("[TB] FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
      end
   endtask

   function automatic bit clientReq(input int c);
      return ((req >> c) & 2'b01) != 2'b00;
   endfunction

   // Model update on each edge from the inputs of the cycle just ended,
   // then comparison of every DUT output just after the edge.
   always @(posedge clk) begin
      int s;
      int now;
      logic [NUM-1:0] e_gnt;
      logic [NUM-1:0] e_done;
      bit e_pulse, e_rxen, e_crc, e_to;
      logic [6:0] e_len;
      cyc = cyc + 1;
      now = cyc;
      s   = now - 1;
      if (rst) begin
         m_owner = -1; m_rr = 0; m_idle_from = now;
         m_aa = '0; m_ch = '0; m_crcinit = '0;
         armed = 1;
      end else begin
         if (m_owner >= 0 && m_done_at >= 0 && s == m_done_at) begin
            m_rr        = (m_owner + 1) % NUM;
            m_owner     = -1;
            m_idle_from = now;
         end else if (m_owner >= 0) begin
            if (s == m_g) begin
               m_aa      = (m_owner == 1) ? req_access_address[63:32] : req_access_address[31:0];
               m_ch      = (m_owner == 1) ? req_channel_number[2*CHW-1:CHW] : req_channel_number[CHW-1:0];
               m_crcinit = (m_owner == 1) ? req_crc_state_init_bit[2*CRCW-1:CRCW] : req_crc_state_init_bit[CRCW-1:0];
               m_rxf     = ((req_rx_after_tx >> m_owner) & 2'b01) != 2'b00;
            end
            if (m_txend < 0 && s >= m_g + 2 && tx_iq_valid_last) begin
               m_txend = s;
               if (!m_rxf) begin
                  m_done_at = s + 1; m_crc = 0; m_to = 0; m_len = '0;
               end else begin
                  m_rxen = s + 1 + IFS;
                  m_toat = m_rxen + RXW;
               end
            end else if (m_rxf && m_txend >= 0 && m_done_at < 0 && s >= m_rxen) begin
               if (rx_decode_end) begin
                  m_done_at = s + 1; m_crc = rx_crc_ok; m_to = 0; m_len = rx_payload_length;
               end else begin
                  if (rx_hit_flag) m_hit = 1;
                  if (!m_hit && s == m_toat - 1) begin
                     m_done_at = m_toat; m_crc = 0; m_to = 1; m_len = '0;
                  end
               end
            end
         end
         if (m_owner < 0 && s >= m_idle_from && req != '0) begin
            for (int i = 0; i < NUM; i++) begin
               if (m_owner < 0 && clientReq((m_rr + i) % NUM)) begin
                  m_owner = (m_rr + i) % NUM;
               end
            end
            m_g = now; m_txend = -1; m_rxen = -1; m_toat = -1; m_done_at = -1;
            m_hit = 0; m_rxf = 0;
         end
      end
      #1;
      if (armed) begin
         e_gnt = '0; e_done = '0; e_pulse = 0; e_rxen = 0; e_crc = 0; e_to = 0; e_len = '0;
         if (m_owner >= 0) begin
            if (now >= m_g && (m_done_at < 0 || now <= m_done_at)) e_gnt = NUM'(1 << m_owner);
            e_pulse = (now == m_g + 1);
            e_rxen  = m_rxf && m_txend >= 0 && now >= m_rxen && (m_done_at < 0 || now < m_done_at);
            if (now == m_done_at) begin
               e_done = NUM'(1 << m_owner); e_crc = m_crc; e_to = m_to; e_len = m_len;
            end
         end
         checkOutput("gnt", gnt, e_gnt);
         checkOutput("done", done, e_done);
         checkOutput("status_crc_ok", status_crc_ok, e_crc);
         checkOutput("status_timeout", status_timeout, e_to);
         checkOutput("status_len", status_payload_length, e_len);
         checkOutput("tx_start", tx_start, e_pulse);
         checkOutput("tx_ch_load", tx_channel_number_load, e_pulse);
         checkOutput("tx_crc_load", tx_crc_state_init_bit_load, e_pulse);
         checkOutput("rx_enable", rx_enable, e_rxen);
         checkOutput("tx_aa", tx_access_address, m_aa);
         checkOutput("rx_ubs", rx_unique_bit_sequence, m_aa);
         checkOutput("tx_ch", tx_channel_number, m_ch);
         checkOutput("rx_ch", rx_channel_number, m_ch);
         checkOutput("tx_crcinit", tx_crc_state_init_bit, m_crcinit);
         checkOutput("rx_crcinit", rx_crc_state_init_bit, m_crcinit);
      end
   end

   // Advance one cycle; inputs are always changed at the falling edge.
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic applyStimulus(input logic [NUM-1:0] r, input logic [NUM-1:0] rxa);
      req             = r;
      req_rx_after_tx = rxa;
   endtask

   task automatic pulseTxLast(output int at);
      at = cyc; tx_iq_valid_last = 1'b1; tick(1); tx_iq_valid_last = 1'b0;
   endtask

   task automatic pulseHit();
      rx_hit_flag = 1'b1; tick(1); rx_hit_flag = 1'b0;
   endtask

   task automatic pulseDecode(input bit crc, input logic [6:0] len, output int at);
      at = cyc; rx_decode_end = 1'b1; rx_crc_ok = crc; rx_payload_length = len;
      tick(1);
      rx_decode_end = 1'b0; rx_crc_ok = 1'b0; rx_payload_length = '0;
   endtask

   function automatic bit evHit(input int which);
      case (which)
         0:       return tx_start;
         1:       return done != '0;
         2:       return rx_enable;
         default: return gnt != '0;
      endcase
   endfunction

   task automatic waitFor(input int which, input int budget, input string name, output int at);
      at = -1;
      for (int n = 0; n < budget; n++) begin
         if (evHit(which)) begin
            at = cyc;
            return;
         end
         tick(1);
      end
      total = total + 1;
      bad   = bad + 1;
      $display("[TB] FAIL %s actual=no-event required=event-within-%0d-cycles", name, budget);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog actual=still-running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int rc, at, m, e, p;
      rst = 1'b1;
      req = '0; req_rx_after_tx = '0;
      req_access_address     = {32'h12345678, 32'h8E89BED6};
      req_channel_number     = {6'd12, 6'd37};
      req_crc_state_init_bit = {24'hABCDEF, 24'h555555};
      tx_iq_valid_last = 0; rx_hit_flag = 0; rx_decode_end = 0;
      rx_crc_ok = 0; rx_payload_length = '0;

      // Reset state
      tick(3);
      checkOutput("rst_gnt", gnt, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_tx_aa", tx_access_address, 0);
      rst = 1'b0;
      tick(2);

      // Client 0, TX only
      $display("[TB] single client 0, TX only");
      applyStimulus(2'b01, 2'b00);
      rc = cyc;
      waitFor(0, 10, "t1_tx_start", at);
      checkOutput("t1_start_latency", at - rc, 2);
      checkOutput("t1_loads", {tx_crc_state_init_bit_load, tx_channel_number_load}, 2'b11);
      checkOutput("t1_aa", tx_access_address, 32'h8E89BED6);
      checkOutput("t1_ubs", rx_unique_bit_sequence, 32'h8E89BED6);
      checkOutput("t1_ch", tx_channel_number, 37);
      tick(5);
      pulseTxLast(m);
      waitFor(1, 10, "t1_done", at);
      checkOutput("t1_done_latency", at - m, 1);
      checkOutput("t1_done_vec", done, 2'b01);
      checkOutput("t1_status", {status_crc_ok, status_timeout, status_payload_length}, 0);
      applyStimulus(2'b00, 2'b00);
      tick(2);

      // Both clients continuously: rr pointer sits at 1 after client 0
      $display("[TB] both clients, round robin");
      applyStimulus(2'b11, 2'b00);
      for (int i = 0; i < 4; i++) begin
         waitFor(0, 10, "t2_tx_start", at);
         tick(3);
         pulseTxLast(m);
         waitFor(1, 10, "t2_done", at);
         checkOutput("t2_done_owner", done, (i % 2 == 0) ? 2'b10 : 2'b01);
         checkOutput("t2_gnt_match", gnt, (i % 2 == 0) ? 2'b10 : 2'b01);
         if (i == 3) applyStimulus(2'b00, 2'b00);
      end
      tick(2);

      // Client 0 with RX: hit 100 cycles into the window, then decode
      $display("[TB] RX with hit and decode");
      applyStimulus(2'b01, 2'b01);
      waitFor(0, 10, "t3_tx_start", at);
      tick(3);
      pulseTxLast(m);
      waitFor(2, IFS + 50, "t3_rx_enable", e);
      checkOutput("t3_ifs_gap", e - m, 2401);
      tick(100);
      pulseHit();
      tick(20);
      pulseDecode(1'b1, 7'd37, p);
      waitFor(1, 10, "t3_done", at);
      checkOutput("t3_done_latency", at - p, 1);
      checkOutput("t3_status", {status_crc_ok, status_timeout, status_payload_length}, {1'b1, 1'b0, 7'd37});
      applyStimulus(2'b00, 2'b00);
      tick(2);

      // Client 1 with RX, no hit: timeout. PHY result lines held busy to
      // show they are not reported on a timeout.
      $display("[TB] RX timeout");
      applyStimulus(2'b10, 2'b10);
      rx_crc_ok = 1'b1; rx_payload_length = 7'd9;
      waitFor(0, 10, "t4_tx_start", at);
      tick(2);
      pulseTxLast(m);
      waitFor(2, IFS + 50, "t4_rx_enable", e);
      waitFor(1, RXW + 50, "t4_done", at);
      checkOutput("t4_timeout_time", at - e, 640);
      checkOutput("t4_done_vec", done, 2'b10);
      checkOutput("t4_status", {status_crc_ok, status_timeout, status_payload_length}, {1'b0, 1'b1, 7'd0});
      applyStimulus(2'b00, 2'b00);
      rx_crc_ok = 1'b0; rx_payload_length = '0;
      tick(2);

      // Decode end coincident with the last window cycle
      $display("[TB] decode coincident with timer zero");
      applyStimulus(2'b01, 2'b01);
      waitFor(0, 10, "t5_tx_start", at);
      tick(2);
      pulseTxLast(m);
      waitFor(2, IFS + 50, "t5_rx_enable", e);
      tick(RXW - 1);
      pulseDecode(1'b0, 7'd5, p);
      waitFor(1, 10, "t5_done", at);
      checkOutput("t5_done_time", at - e, 640);
      checkOutput("t5_status", {status_crc_ok, status_timeout, status_payload_length}, {1'b0, 1'b0, 7'd5});
      applyStimulus(2'b00, 2'b00);
      tick(2);

      // Reset while in the RX window, then a fresh request from client 1
      $display("[TB] reset during RX window");
      applyStimulus(2'b01, 2'b01);
      waitFor(0, 10, "t6_tx_start", at);
      tick(2);
      pulseTxLast(m);
      waitFor(2, IFS + 50, "t6_rx_enable", e);
      tick(10);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      applyStimulus(2'b00, 2'b00);
      checkOutput("t6_rst_gnt", gnt, 0);
      checkOutput("t6_rst_rxen", rx_enable, 0);
      checkOutput("t6_rst_aa", tx_access_address, 0);
      tick(2);
      applyStimulus(2'b10, 2'b00);
      rc = cyc;
      waitFor(3, 10, "t6_gnt", at);
      checkOutput("t6_gnt_latency", at - rc, 1);
      checkOutput("t6_gnt_vec", gnt, 2'b10);
      waitFor(0, 10, "t6_tx_start", at);
      checkOutput("t6_aa", tx_access_address, 32'h12345678);
      tick(2);
      pulseTxLast(m);
      waitFor(1, 10, "t6_done", at);
      checkOutput("t6_done_vec", done, 2'b10);
      applyStimulus(2'b00, 2'b00);
      tick(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
